// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode CSR access and ECALL/MRET trap sequencer; defining CSR_MSCRATCH_EN adds mscratch at 0x340
module csr_trap_ctrl #(
  parameter logic [31:0] MTVEC_RST   = 32'h0,
  parameter logic [31:0] MSTATUS_RST = 32'h1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  localparam logic [2:0] IDLE = 3'd0, EXEC = 3'd1, TRAP0 = 3'd2, TRAP1 = 3'd3, RESP = 3'd4;
  localparam logic [2:0] OP_RW = 3'd0, OP_RS = 3'd1, OP_RC = 3'd2, OP_ECALL = 3'd3, OP_MRET = 3'd4;
  logic [2:0]  state, op_q;
  logic [11:0] csr_q;
  logic [31:0] wdata_q;
  logic [31:2] pc_q;
  logic        mie, mpie;
  logic [31:0] mtvec, mepc, mcause;
`ifdef CSR_MSCRATCH_EN
  logic [31:0] mscratch;
`endif
  logic [31:0] mstatus_rd, old, nv, rdata_q, rpc_q;
  logic        legal, wr, ill_q, redir_q;
  // MPP always reads as machine mode; only MIE and MPIE are stored
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
  // Decode the captured CSR address and form the read-modify-write value
  always_comb begin
    old = '0;
    legal = 1'b1;
    case (csr_q)
      12'h300: old = mstatus_rd;
      12'h305: old = mtvec;
      12'h341: old = mepc;
      12'h342: old = mcause;
`ifdef CSR_MSCRATCH_EN
      12'h340: old = mscratch;
`endif
      default: legal = 1'b0;
    endcase
    nv = op_q == OP_RW ? wdata_q : op_q == OP_RS ? old | wdata_q : old & ~wdata_q;
    wr = legal && op_q <= OP_RC && (op_q == OP_RW || wdata_q != '0);
  end
  // Sequencer FSM plus CSR state and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      op_q <= '0;
      csr_q <= '0;
      wdata_q <= '0;
      pc_q <= '0;
      mie <= MSTATUS_RST[3];
      mpie <= MSTATUS_RST[7];
      mtvec <= {MTVEC_RST[31:2], 2'b00};
      mepc <= '0;
      mcause <= '0;
`ifdef CSR_MSCRATCH_EN
      mscratch <= '0;
`endif
      rdata_q <= '0;
      ill_q <= 1'b0;
      redir_q <= 1'b0;
      rpc_q <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q <= req_op;
          csr_q <= req_csr;
          wdata_q <= req_wdata;
          pc_q <= req_pc[31:2];
          rdata_q <= '0;
          ill_q <= 1'b0;
          redir_q <= 1'b0;
          rpc_q <= '0;
          state <= req_op == OP_ECALL ? TRAP0 : EXEC;
        end
        EXEC: begin
          state <= RESP;
          if (op_q <= OP_RC) begin
            rdata_q <= old;
            ill_q <= !legal;
          end else if (op_q == OP_MRET) begin
            mie <= mpie;
            mpie <= 1'b1;
            redir_q <= 1'b1;
            rpc_q <= mepc;
          end else
            ill_q <= 1'b1;
          if (wr)
            case (csr_q)
              12'h300: begin
                mie <= nv[3];
                mpie <= nv[7];
              end
              12'h305: mtvec <= {nv[31:2], 2'b00};
              12'h341: mepc <= {nv[31:2], 2'b00};
              12'h342: mcause <= nv;
`ifdef CSR_MSCRATCH_EN
              12'h340: mscratch <= nv;
`endif
              default: ;
            endcase
        end
        TRAP0: begin
          mepc <= {pc_q, 2'b00};
          mcause <= 32'd11;
          state <= TRAP1;
        end
        TRAP1: begin
          mpie <= mie;
          mie <= 1'b0;
          redir_q <= 1'b1;
          rpc_q <= mtvec;
          state <= RESP;
        end
        RESP: if (resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign req_ready      = rst && state == IDLE;
  assign resp_valid     = state == RESP;
  assign resp_rdata     = resp_valid ? rdata_q : '0;
  assign resp_illegal   = resp_valid && ill_q;
  assign redirect_valid = resp_valid && redir_q;
  assign redirect_pc    = resp_valid ? rpc_q : '0;
endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: scoreboard bench for csr_trap_ctrl
module tb_csr_trap_ctrl;
  logic        clk = 0, rst = 0, req_valid = 0, resp_ready = 0;
  logic [2:0]  req_op = 0;
  logic [11:0] req_csr = 0;
  logic [31:0] req_wdata = 0, req_pc = 0;
  logic        req_ready, resp_valid, resp_illegal, redirect_valid;
  logic [31:0] resp_rdata, redirect_pc;
  typedef struct {logic [31:0] rdata; logic ill; logic rv; logic [31:0] rpc; int lat;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscr;
  always #5 clk = ~clk;
  csr_trap_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr(req_csr), .req_wdata(req_wdata), .req_pc(req_pc), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic m_read(input logic [11:0] c, output logic [31:0] v, output logic ok);
    ok = 1;
    v = 0;
    case (c)
      12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h305: v = m_mtvec;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
`ifdef CSR_MSCRATCH_EN
      12'h340: v = m_mscr;
`endif
      default: ok = 0;
    endcase
  endtask
  task automatic model(input logic [2:0] op, input logic [11:0] c, input logic [31:0] wd, input logic [31:0] pc, output exp_t e);
    logic [31:0] o, n;
    logic ok;
    e = '{rdata: 0, ill: 0, rv: 0, rpc: 0, lat: 2};
    if (op <= 2) begin
      m_read(c, o, ok);
      e.rdata = o;
      e.ill = !ok;
      n = op == 0 ? wd : op == 1 ? (o | wd) : (o & ~wd);
      if (ok && (op == 0 || wd != 0))
        case (c)
          12'h300: begin m_mie = n[3]; m_mpie = n[7]; end
          12'h305: m_mtvec = n & ~32'h3;
          12'h341: m_mepc = n & ~32'h3;
          12'h342: m_mcause = n;
          default: m_mscr = n;
        endcase
    end else if (op == 3) begin
      m_mepc = pc & ~32'h3;
      m_mcause = 11;
      m_mpie = m_mie;
      m_mie = 0;
      e.rv = 1;
      e.rpc = m_mtvec;
      e.lat = 3;
    end else if (op == 4) begin
      m_mie = m_mpie;
      m_mpie = 1;
      e.rv = 1;
      e.rpc = m_mepc;
    end else
      e.ill = 1;
  endtask
  task automatic do_reset();
    #1 rst = 0;
    req_valid = 0;
    resp_ready = 0;
    q.delete();
    {m_mie, m_mpie, m_mtvec, m_mepc, m_mcause, m_mscr} = '0;
    #2;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_illegal", 32'(resp_illegal), 0);
    check("rst_redir_v", 32'(redirect_valid), 0);
    check("rst_redir_pc", redirect_pc, 0);
    @(negedge clk) rst = 1;
    #1 check("rel_req_ready", 32'(req_ready), 1);
  endtask
  task automatic send(input logic [2:0] op, input logic [11:0] c, input logic [31:0] wd, input logic [31:0] pc, input int hold);
    exp_t e, x;
    int n, lat;
    model(op, c, wd, pc, e);
    q.push_back(e);
    @(negedge clk);
    req_valid = 1; req_op = op; req_csr = c; req_wdata = wd; req_pc = pc;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_wait", 32'(req_ready), 1);
    @(posedge clk) #1 req_valid = 0;
    req_wdata = ~wd;
    req_csr = 12'h342;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk) #1; lat++; end
    x = q.pop_front();
    check("latency", lat, x.lat);
    check("rdata", resp_rdata, x.rdata);
    check("illegal", 32'(resp_illegal), 32'(x.ill));
    check("redir_v", 32'(redirect_valid), 32'(x.rv));
    if (x.rv) check("redir_pc", redirect_pc, x.rpc);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_op = 0; req_csr = 12'h342; req_wdata = $urandom;
      @(posedge clk) #1;
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_rdata", resp_rdata, x.rdata);
      check("hold_req_ready", 32'(req_ready), 0);
    end
    req_valid = 0;
    resp_ready = 1;
    @(posedge clk) #1 resp_ready = 0;
    check("post_resp_valid", 32'(resp_valid), 0);
    check("post_req_ready", 32'(req_ready), 1);
  endtask
  initial begin
    logic [11:0] addrs [5] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340};
    do_reset();
    send(1, 12'h300, 0, 0, 0);
    send(0, 12'h305, 32'h8000_0103, 0, 0);
    send(1, 12'h305, 0, 0, 0);
    send(3, 0, 0, 32'h8000_0040, 0);
    send(1, 12'h341, 0, 0, 0);
    send(1, 12'h342, 0, 0, 0);
    send(1, 12'h300, 8, 0, 0);
    send(3, 0, 0, 32'h8000_0047, 0);
    send(1, 12'h300, 0, 0, 0);
    send(4, 0, 0, 0, 0);
    send(1, 12'h300, 0, 0, 0);
    send(0, 12'h342, 32'h1234_5678, 0, 5);
    send(1, 12'h342, 0, 0, 0);
    send(0, 12'h7C0, 32'hFFFF_FFFF, 0, 0);
    send(6, 12'h300, 32'hFFFF_FFFF, 0, 0);
    send(1, 12'h300, 0, 0, 0);
    send(0, 12'h340, 32'hDEAD_BEEF, 0, 0);
    send(1, 12'h340, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      send(3'($urandom_range(0, 2)), addrs[$urandom_range(0, 4)], ($urandom_range(0, 3) == 0) ? 0 : $urandom, 0, $urandom_range(0, 2));
    @(negedge clk);
    req_valid = 1; req_op = 3; req_pc = 32'h0000_1230;
    @(posedge clk) #1 req_valid = 0;
    @(posedge clk);
    do_reset();
    send(1, 12'h341, 0, 0, 0);
    send(1, 12'h300, 0, 0, 0);
    send(1, 12'h342, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
